// File: rtl/event_rr_arbiter.sv
// Edge-detecting event latch with a round-robin offer port and sticky overflow tracking.
// Define EVENT_ARB_OVF_COUNT_EN to enable the saturating lost-event counter on ovf_count.
module event_rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int ID_W   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] evt_in,
  input  logic              evt_ready,
  input  logic              clr_ovf,
  output logic              evt_valid,
  output logic [ID_W-1:0]   evt_id,
  output logic [NUM_CH-1:0] pending,
  output logic              overflow,
  output logic [7:0]        ovf_count
);

  // Handshake: an event transfers on a rising edge where evt_valid && evt_ready;
  // while evt_valid is high, evt_id holds until that transfer happens.
  typedef enum logic {IDLE, OFFER} state_t;

  state_t              state_q;
  logic [NUM_CH-1:0]   prev_q;
  logic [NUM_CH-1:0]   pending_q;
  logic [NUM_CH-1:0]   pending_d;
  logic [ID_W-1:0]     last_q;
  logic [ID_W-1:0]     id_q;
  logic                ovf_q;

  logic [NUM_CH-1:0]   rise;
  logic [NUM_CH-1:0]   clr_mask;
  logic [NUM_CH-1:0]   drop;
  logic [ID_W-1:0]     sel_id;
  logic                found;
  logic                load;
  int                  idx;

  always_comb begin
    rise   = evt_in & ~prev_q;
    found  = 1'b0;
    sel_id = last_q;
    idx    = 0;
    // First pending channel strictly after the last grant, wrapping.
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = (int'(last_q) + i) % NUM_CH;
      if (!found && pending_q[idx]) begin
        found  = 1'b1;
        sel_id = ID_W'(idx);
      end
    end
    load      = found && ((state_q == IDLE) || evt_ready);
    clr_mask  = load ? (NUM_CH'(1) << sel_id) : '0;
    drop      = rise & pending_q & ~clr_mask;
    pending_d = (pending_q & ~clr_mask) | rise;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      prev_q    <= '0;
      pending_q <= '0;
      last_q    <= ID_W'(NUM_CH - 1);
      id_q      <= '0;
      ovf_q     <= 1'b0;
    end else begin
      prev_q    <= evt_in;
      pending_q <= pending_d;
      if (|drop) begin
        ovf_q <= 1'b1;
      end else if (clr_ovf) begin
        ovf_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (load) begin
            id_q    <= sel_id;
            last_q  <= sel_id;
            state_q <= OFFER;
          end
        end
        OFFER: begin
          if (load) begin
            id_q   <= sel_id;
            last_q <= sel_id;
          end else if (evt_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign evt_valid = (state_q == OFFER);
  assign evt_id    = id_q;
  assign pending   = pending_q;
  assign overflow  = ovf_q;

`ifdef EVENT_ARB_OVF_COUNT_EN
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic [7:0] cnt_base;
  logic [8:0] cnt_sum;
  logic [4:0] drop_cnt;

  always_comb begin
    drop_cnt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      drop_cnt = drop_cnt + 5'(drop[i]);
    end
    // A clear coinciding with drops restarts the count from the new drops.
    cnt_base = clr_ovf ? 8'd0 : cnt_q;
    cnt_sum  = {1'b0, cnt_base} + 9'(drop_cnt);
    cnt_d    = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign ovf_count = cnt_q;
`else
  assign ovf_count = '0;
`endif

endmodule

// File: tb/tb_event_rr_arbiter.sv
// Directed bench for event_rr_arbiter: expected grant ids queue up at stimulus time and a
// negedge monitor pops them on every handshake; direct checks cover latency and status.
module tb_event_rr_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] evt_in;
  logic       evt_ready;
  logic       clr_ovf;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic [3:0] pending;
  logic       overflow;
  logic [7:0] ovf_count;

  logic [1:0] exp_q[$];
  int         vec_cnt = 0;
  int         err_cnt = 0;

`ifdef EVENT_ARB_OVF_COUNT_EN
  localparam logic [7:0] EXP_CNT2 = 8'd2;
  localparam logic [7:0] EXP_CNT1 = 8'd1;
`else
  localparam logic [7:0] EXP_CNT2 = 8'd0;
  localparam logic [7:0] EXP_CNT1 = 8'd0;
`endif

  event_rr_arbiter #(.NUM_CH(4), .ID_W(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .evt_in    (evt_in),
    .evt_ready (evt_ready),
    .clr_ovf   (clr_ovf),
    .evt_valid (evt_valid),
    .evt_id    (evt_id),
    .pending   (pending),
    .overflow  (overflow),
    .ovf_count (ovf_count)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic reset_dut();
    reset     = 1'b1;
    evt_ready = 1'b0;
    clr_ovf   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic drain(input string name);
    bit done;
    done      = 1'b0;
    evt_ready = 1'b1;
    for (int n = 0; n < 60 && !done; n++) begin
      tick();
      if (exp_q.size() == 0 && !evt_valid) done = 1'b1;
    end
    check({name, "_drain"}, 32'(done), 32'd1);
  endtask

  // Scoreboard monitor: every handshake must match the oldest expected id.
  always @(negedge clk) begin
    logic [1:0] e;
    if (!reset && evt_valid && evt_ready) begin
      vec_cnt++;
      if (exp_q.size() == 0) begin
        err_cnt++;
        $display("FAIL handshake: got id %0d expected no event", evt_id);
      end else begin
        e = exp_q.pop_front();
        if (evt_id !== e) begin
          err_cnt++;
          $display("FAIL handshake: got id %0d expected %0d", evt_id, e);
        end
      end
    end
  end

  initial begin
    evt_in    = '0;
    evt_ready = 1'b0;
    clr_ovf   = 1'b0;
    reset     = 1'b1;
    #1;
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_count", 32'(ovf_count), 32'd0);
    check("rst_id", 32'(evt_id), 32'd0);
    reset_dut();

    // Single rise on channel 2, ready held high
    evt_ready = 1'b1;
    evt_in    = 4'b0100;
    exp_q.push_back(2'd2);
    tick();
    check("t1_pending", 32'(pending), 32'h4);
    check("t1_valid_k", 32'(evt_valid), 32'd0);
    tick();
    check("t1_valid_k1", 32'(evt_valid), 32'd1);
    check("t1_id_k1", 32'(evt_id), 32'd2);
    check("t1_pend_k1", 32'(pending), 32'h0);
    tick();
    check("t1_idle", 32'(evt_valid), 32'd0);
    tick();
    tick();
    check("t1_held_once", 32'(evt_valid), 32'd0);
    evt_in = '0;
    drain("t1");

    // Three simultaneous rises, then wrap from last_grant=3
    reset_dut();
    evt_ready = 1'b1;
    evt_in    = 4'b1011;
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd3);
    tick();
    check("t2_pending", 32'(pending), 32'hB);
    tick();
    check("t2_id0", 32'(evt_id), 32'd0);
    tick();
    check("t2_id1", 32'(evt_id), 32'd1);
    tick();
    check("t2_id3", 32'(evt_id), 32'd3);
    check("t2_valid3", 32'(evt_valid), 32'd1);
    tick();
    check("t2_idle", 32'(evt_valid), 32'd0);
    evt_in = '0;
    tick();
    evt_in = 4'b1001;
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd3);
    drain("t2");
    evt_in = '0;

    // Held offer with a second rise on the offered channel
    reset_dut();
    evt_in = 4'b0010;
    exp_q.push_back(2'd1);
    tick();
    tick();
    for (int c = 0; c < 5; c++) begin
      check("t3_hold_valid", 32'(evt_valid), 32'd1);
      check("t3_hold_id", 32'(evt_id), 32'd1);
      if (c == 1) evt_in = 4'b0000;
      if (c == 2) evt_in = 4'b0010;
      tick();
    end
    check("t3_pending", 32'(pending), 32'h2);
    check("t3_no_ovf", 32'(overflow), 32'd0);
    exp_q.push_back(2'd1);
    drain("t3");
    evt_in = '0;

    // Overflow on a pending, unserved channel; clear; clear+drop collision
    reset_dut();
    evt_in = 4'b0001;
    exp_q.push_back(2'd0);
    tick();
    tick();
    evt_in = 4'b0011;
    tick();
    check("t4_pend1", 32'(pending), 32'h2);
    check("t4_no_ovf", 32'(overflow), 32'd0);
    for (int r = 0; r < 2; r++) begin
      evt_in = 4'b0001;
      tick();
      evt_in = 4'b0011;
      tick();
    end
    check("t4_ovf", 32'(overflow), 32'd1);
    check("t4_count", 32'(ovf_count), 32'(EXP_CNT2));
    check("t4_pend_kept", 32'(pending), 32'h2);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("t4_clr_ovf", 32'(overflow), 32'd0);
    check("t4_clr_count", 32'(ovf_count), 32'd0);
    evt_in = 4'b0001;
    tick();
    evt_in  = 4'b0011;
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("t4_clr_vs_drop", 32'(overflow), 32'd1);
    check("t4_clr_vs_cnt", 32'(ovf_count), 32'(EXP_CNT1));
    tick();
    check("t4_sticky", 32'(overflow), 32'd1);
    exp_q.push_back(2'd1);
    drain("t4");
    evt_in = '0;

    // Rise on a channel in the cycle its pending bit is consumed by a load
    reset_dut();
    evt_in = 4'b0001;
    exp_q.push_back(2'd0);
    tick();
    tick();
    evt_in = 4'b0101;
    tick();
    evt_in = 4'b0001;
    tick();
    evt_in    = 4'b0101;
    evt_ready = 1'b1;
    exp_q.push_back(2'd2);
    tick();
    check("t5_pending", 32'(pending), 32'h4);
    check("t5_no_ovf", 32'(overflow), 32'd0);
    check("t5_id", 32'(evt_id), 32'd2);
    exp_q.push_back(2'd2);
    drain("t5");
    evt_in = '0;

    // Asynchronous reset mid-offer with the line held high through release
    reset_dut();
    evt_in = 4'b1000;
    tick();
    tick();
    check("t6_offer", 32'(evt_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_valid", 32'(evt_valid), 32'd0);
    check("t6_async_pend", 32'(pending), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.push_back(2'd3);
    tick();
    check("t6_rise_after_rel", 32'(pending), 32'h8);
    drain("t6");
    for (int n = 0; n < 4; n++) tick();
    check("t6_single_event", 32'(evt_valid), 32'd0);
    check("t6_pend_empty", 32'(pending), 32'd0);
    evt_in = '0;

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/event_rr_arbiter.md
EVENT_RR_ARBITER -- requirements
Module: event_rr_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, meaning the number of event channels (legal range 2..16).
REQ-002 The block SHALL have parameter ID_W, default 2, meaning the channel-id width; the constraint 2^ID_W >= NUM_CH SHALL hold.
REQ-003 Port `clk`: input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 Port `reset`: input, 1 bit, asynchronous, active-high.
REQ-005 Port `evt_in`: input, NUM_CH bits, raw level event lines, one per channel, synchronous to `clk`.
REQ-006 Port `evt_ready`: input, 1 bit, consumer accepts the offered event.
REQ-007 Port `clr_ovf`: input, 1 bit, clears the overflow status.
REQ-008 Port `evt_valid`: output, 1 bit, an event is offered.
REQ-009 Port `evt_id`: output, ID_W bits, channel of the offered event.
REQ-010 Port `pending`: output, NUM_CH bits, latched unserved events.
REQ-011 Port `overflow`: output, 1 bit, sticky lost-event flag.
REQ-012 Port `ovf_count`: output, 8 bits, count of lost events (see Configuration).

Function
REQ-013 Per channel, the block SHALL register the previous `evt_in` value and form rise[i] = evt_in[i] & ~prev[i].
REQ-014 A rise SHALL set pending[i] at the same clock edge; an input held high SHALL produce exactly one rise.
REQ-015 FSM states SHALL be IDLE (evt_valid=0) and OFFER (evt_valid=1).
REQ-016 IDLE, with pending nonzero: the block SHALL select a channel round-robin, load evt_id, clear that pending bit, and enter OFFER.
REQ-017 Round-robin search SHALL start at last_grant+1 and wrap modulo NUM_CH; last_grant SHALL update on every load.
REQ-018 OFFER: evt_valid and evt_id SHALL hold stable until a cycle in which evt_ready=1.
REQ-019 On handshake with pending nonzero, the block SHALL load the next channel in the same cycle and stay in OFFER (one event per cycle sustained).
REQ-020 On handshake with pending zero, the block SHALL return to IDLE.
REQ-021 Latency: evt_in rising before edge k (low at k-1) SHALL give pending[i]=1 after edge k and, from IDLE, evt_valid=1 with evt_id=i after edge k+1.
REQ-022 A rise on a channel in the same cycle its pending bit is cleared by a load SHALL leave pending=1 with no overflow.
REQ-023 A rise on a channel whose pending bit is already set and not being cleared SHALL be dropped and SHALL set `overflow`.
REQ-024 `overflow` SHALL remain set until `clr_ovf`=1.
REQ-025 When `clr_ovf` and a new overflow occur in the same cycle, the new overflow SHALL take priority: overflow=1.

Reset
REQ-026 `reset`=1 SHALL asynchronously clear prev, pending, last_grant (set to NUM_CH-1, giving channel 0 first priority), evt_id, evt_valid, overflow and ovf_count, and force the state to IDLE.
REQ-027 A reset during OFFER SHALL drop evt_valid immediately, and the offered event SHALL be lost.
REQ-028 After reset release, a line already high SHALL register one rise on the first edge.

Configuration
REQ-029 With macro EVENT_ARB_OVF_COUNT_EN defined, `ovf_count` SHALL increment by 1 per dropped rise (multiple simultaneous drops add their number), saturate at 255, and be cleared by `clr_ovf`; when clear and drops coincide, the count SHALL equal the number of new drops.
REQ-030 Without EVENT_ARB_OVF_COUNT_EN, `ovf_count` SHALL be constant 0 and no counter logic SHALL be present; `overflow` SHALL be unaffected.

Verification
REQ-031 evt_in[2] 0->1 with evt_ready=1 held -> pending[2]=1 after 1 edge, evt_valid=1 with evt_id=2 after 2 edges, valid for 1 cycle, then IDLE.
REQ-032 Rises on channels 0, 1 and 3 in one cycle with evt_ready=1 -> ids 0, 1, 3 on 3 consecutive cycles; then a rise on channel 0 with channel 3 also pending -> serves 0 before 3 (wrap from last_grant=3).
REQ-033 Channel 1 offered with evt_ready=0 for 5 cycles -> evt_id=1 and evt_valid=1 stable for all 5 cycles; a second rise on channel 1 during that time sets pending[1] and no overflow.
REQ-034 Channel 1 pending, not served, plus two more rises on it -> overflow=1 and ovf_count=2 (macro on) or ovf_count=0 (macro off); clr_ovf pulse -> both 0.
REQ-035 Reset asserted mid-OFFER -> evt_valid=0 and pending=0 without a clock edge; evt_in held high through release -> one event for that channel only.
